// File: rtl/ps2_pkg.sv
// ps2_pkg: types and constants shared by the PS/2 frame receiver.
//   ps2_state_e   - receiver FSM states (IDLE, DATA, PARITY, STOP)
//   PS2_DATA_BITS - data bits per frame
//   PS2_LAST_BIT  - bit counter value of the final data bit
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_e;

   localparam int         PS2_DATA_BITS = 8;
   localparam logic [2:0] PS2_LAST_BIT  = 3'd7;

endpackage

// File: rtl/ps2_frame_rx_if.sv
// ps2_frame_rx_if: PS/2 line inputs and received-byte outputs of ps2_frame_rx.
//   ps2_clk, ps2_data - raw PS/2 lines (idle high)
//   rx_data           - last received byte
//   rx_valid          - one-cycle pulse, rx_data updated
//   parity_err        - parity result of the last delivered byte
//   frame_err         - one-cycle pulse on bad stop bit or timeout
//   busy              - receiver is inside a frame
// Modports: master = line driver / byte consumer, slave = the receiver.
interface ps2_frame_rx_if;
   import ps2_pkg::*;

   logic                     ps2_clk;
   logic                     ps2_data;
   logic [PS2_DATA_BITS-1:0] rx_data;
   logic                     rx_valid;
   logic                     parity_err;
   logic                     frame_err;
   logic                     busy;

   modport master (
      output ps2_clk, ps2_data,
      input  rx_data, rx_valid, parity_err, frame_err, busy
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output rx_data, rx_valid, parity_err, frame_err, busy
   );

endinterface

// File: rtl/ps2_edge_sync.sv
// ps2_edge_sync: synchronizes the raw PS/2 clock and data lines into the
// system clock domain and flags falling edges of the PS/2 clock.
//   clk, clear   - system clock, asynchronous active-high reset
//   ps2_clk_i    - raw PS/2 clock
//   ps2_data_i   - raw PS/2 data
//   clk_sync_o   - synchronized PS/2 clock
//   data_sync_o  - synchronized PS/2 data, aligned with fe_o
//   fe_o         - one-cycle falling-edge strobe, SYNC_STAGES+1 clocks after the pin edge
module ps2_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic clear,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic clk_sync_o,
   output logic data_sync_o,
   output logic fe_o
);

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] data_sync_q;
   logic                   clk_prev_q;
   logic                   fe_q;
   logic                   data_q;

   // Lines idle high, so the chains reset to 1 to avoid a phantom edge.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         clk_prev_q  <= 1'b1;
         fe_q        <= 1'b0;
         data_q      <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
         clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
         // Edge strobe and data sample are registered together so the bit
         // presented with fe_o is the one present at the edge.
         fe_q        <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
         data_q      <= data_sync_q[SYNC_STAGES-1];
      end
   end

   assign clk_sync_o  = clk_sync_q[SYNC_STAGES-1];
   assign data_sync_o = data_q;
   assign fe_o        = fe_q;

endmodule

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver. Assembles 11-bit frames
// (start, 8 data LSB-first, odd parity, stop) and delivers one byte per frame.
//   clk, clear - system clock, asynchronous active-high reset
//   bus        - ps2_frame_rx_if.slave: ps2_clk/ps2_data in; rx_data,
//                rx_valid, parity_err, frame_err, busy out
// Parameters: SYNC_STAGES (>=2) synchronizer depth, TIMEOUT_CYCLES idle
// clocks before a partial frame is abandoned.
// Build option: define PS2_RX_TIMEOUT_EN to enable the partial-frame timeout;
// without it a partial frame waits indefinitely for the next edge.
module ps2_frame_rx #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic           clk,
   input  logic           clear,
   ps2_frame_rx_if.slave  bus
);
   import ps2_pkg::*;

   logic fe;
   logic dat;
   logic ps2_clk_sync_unused;

   ps2_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .clk         (clk),
      .clear       (clear),
      .ps2_clk_i   (bus.ps2_clk),
      .ps2_data_i  (bus.ps2_data),
      .clk_sync_o  (ps2_clk_sync_unused),
      .data_sync_o (dat),
      .fe_o        (fe)
   );

   ps2_state_e               state_q, state_d;
   logic [2:0]               bitcnt_q, bitcnt_d;
   logic [PS2_DATA_BITS-1:0] shreg_q, shreg_d;
   logic [PS2_DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                     par_q, par_d;
   logic                     rx_valid_q, rx_valid_d;
   logic                     perr_q, perr_d;
   logic                     ferr_q, ferr_d;
   logic                     timeout;

`ifdef PS2_RX_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_q, to_d;

   // Counts clocks since the last edge while inside a frame.
   always_comb begin
      to_d = to_q + TO_W'(1);
      if (state_q == IDLE || fe) begin
         to_d = '0;
      end
      timeout = (to_d == TO_W'(TIMEOUT_CYCLES));
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         to_q <= '0;
      end else begin
         to_q <= to_d;
      end
   end
`else
   logic [$clog2(TIMEOUT_CYCLES + 1)-1:0] to_width_unused;

   assign to_width_unused = '0;
   assign timeout         = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      bitcnt_d   = bitcnt_q;
      shreg_d    = shreg_q;
      rx_data_d  = rx_data_q;
      par_d      = par_q;
      perr_d     = perr_q;
      rx_valid_d = 1'b0;
      ferr_d     = 1'b0;

      case (state_q)
         IDLE: begin
            // A high bit on an edge while idle is line noise, not an error.
            if (fe && !dat) begin
               state_d  = DATA;
               bitcnt_d = 3'd0;
            end
         end
         DATA: begin
            if (fe) begin
               shreg_d  = {dat, shreg_q[PS2_DATA_BITS-1:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == PS2_LAST_BIT) begin
                  state_d = PARITY;
               end
            end
         end
         PARITY: begin
            if (fe) begin
               par_d   = dat;
               state_d = STOP;
            end
         end
         STOP: begin
            if (fe) begin
               state_d = IDLE;
               if (dat) begin
                  // Bytes with bad parity are still delivered and flagged.
                  rx_data_d  = shreg_q;
                  rx_valid_d = 1'b1;
                  perr_d     = ~(^{shreg_q, par_q});
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Only asserts without an edge, so it cannot collide with delivery.
      if (timeout) begin
         state_d = IDLE;
         ferr_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q    <= IDLE;
         bitcnt_q   <= 3'd0;
         shreg_q    <= '0;
         rx_data_q  <= '0;
         par_q      <= 1'b0;
         rx_valid_q <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bitcnt_q   <= bitcnt_d;
         shreg_q    <= shreg_d;
         rx_data_q  <= rx_data_d;
         par_q      <= par_d;
         rx_valid_q <= rx_valid_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
      end
   end

   assign bus.rx_data    = rx_data_q;
   assign bus.rx_valid   = rx_valid_q;
   assign bus.parity_err = perr_q;
   assign bus.frame_err  = ferr_q;
   assign bus.busy       = (state_q != IDLE);

endmodule

// File: doc/ps2_frame_rx.md
# ps2_frame_rx

PS/2 device-to-host frame receiver. It samples the raw keyboard lines `ps2_clk`/`ps2_data` in the system clock domain and tracks bit position with a 3-bit data-bit counter. It assembles each 11-bit frame (start, 8 data LSB-first, odd parity, stop) and presents one received byte per frame to the scan-code decoding stage downstream.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth on `ps2_clk` and `ps2_data`; minimum 2.
- `TIMEOUT_CYCLES`, 10000: system clocks without a `ps2_clk` falling edge before a partial frame is abandoned (100 µs at 100 MHz).

Ports:
- `clk`  in  1: system clock; all logic rising-edge.
- `clear`  in  1: reset, asynchronous, active-high.
- `ps2_clk`  in  1: raw PS/2 clock, asynchronous to `clk`, idles high.
- `ps2_data`  in  1: raw PS/2 data, asynchronous, idles high.
- `rx_data`  out  8: last received byte; holds until the next accepted frame.
- `rx_valid`  out  1: one-cycle pulse, `rx_data` updated this cycle.
- `parity_err`  out  1: valid only with `rx_valid`; 1 if the parity check failed.
- `frame_err`  out  1: one-cycle pulse for a bad stop bit or a timeout.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- Both inputs pass through `SYNC_STAGES` flops. Synchronizer flops reset to 1.
- Falling edge `fe` = previous synchronized `ps2_clk` is 1 and current is 0. The data bit is sampled from synchronized `ps2_data` in the same cycle as `fe`.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fe` with data=0 (start bit), go to DATA and clear `bitcnt` to 0. On `fe` with data=1, remain in IDLE; this is not an error.
  - DATA: on `fe`, shift the bit into `shreg[7]` (right shift, so LSB-first lands correctly) and increment `bitcnt`. When `fe` arrives with `bitcnt`==7, go to PARITY. `bitcnt` wraps 7→0.
  - PARITY: on `fe`, latch the bit, go to STOP.
  - STOP: on `fe` with data=1, go to IDLE with `rx_data`←`shreg` and pulse `rx_valid`. Set `parity_err` = ~(^{shreg, parity_bit}), i.e. the total count of ones across data and parity must be odd. On `fe` with data=0, pulse `frame_err`, do not update `rx_data`, and go to IDLE.
- A frame with a parity error is still delivered (`rx_valid`=1, `parity_err`=1). The downstream stage decides whether to discard it.
- `rx_valid` and `frame_err` are never high in the same cycle.
- Reset values: `rx_data`=8'h00, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, FSM=IDLE, `bitcnt`=0, `shreg`=0.
- Asserting `clear` mid-frame aborts immediately, with no pulse on any output. After deassertion the receiver waits for a fresh start bit.

## Timing
- Latency from a `ps2_clk` pin falling edge to the `fe` cycle: `SYNC_STAGES`+1 clocks.
- `rx_valid` and `frame_err` are registered. Each asserts the cycle after the stop-bit `fe` and lasts exactly 1 cycle.
- `parity_err` updates in the same cycle as `rx_valid` and holds until the next `rx_valid`.
- `busy` rises the cycle after the start-bit `fe` and falls in the same cycle `rx_valid`/`frame_err` asserts.
- Back-to-back frames: a start-bit `fe` arriving in the cycle the FSM returns to IDLE is accepted.

## Configuration
- `PS2_RX_TIMEOUT_EN` defined: a timeout counter of width $clog2(`TIMEOUT_CYCLES`+1) runs while the FSM is not in IDLE and is cleared on every `fe`. On reaching `TIMEOUT_CYCLES` the FSM returns to IDLE and `frame_err` pulses once.
- `PS2_RX_TIMEOUT_EN` undefined: there is no timeout counter, and a partial frame waits indefinitely for the next edge.

## Structure
- Shared package `ps2_pkg` holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - the constant `PS2_DATA_BITS`=8;
  - the constant `PS2_LAST_BIT`=3'd7.
- Sub-module `ps2_edge_sync`: the parameterized synchronizer plus falling-edge detector. It outputs the synchronized clock, synchronized data and `fe`.

## Test plan
- Send byte 0x1C with parity bit 0 and stop bit 1 → a single `rx_valid` pulse with `rx_data`=8'h1C and `parity_err`=0, arriving `SYNC_STAGES`+2 clocks after the stop edge.
- Send byte 0xF0 with parity bit 0 (wrong; the correct parity bit is 1) → `rx_valid` pulses, `rx_data`=8'hF0, `parity_err`=1.
- Send byte 0x5A with stop bit 0 → `frame_err` pulses for 1 cycle, `rx_valid` stays 0, and `rx_data` keeps its previous value.
- With the macro defined and `TIMEOUT_CYCLES`=100, stop `ps2_clk` after 4 data bits → `frame_err` pulses once, 100 clocks after the last `fe`, and `busy` falls. A following frame carrying 0x1C is then received correctly.
- Assert `clear` after the 5th data bit → all outputs go to their reset values and no pulses occur. Then send 0x29 → `rx_data`=8'h29 and `parity_err`=0.
- Send 0xE0 and 0x75 back-to-back with minimal idle time → two `rx_valid` pulses, in that order, with correct data.
